blit_sequencer: RTL and testbench

//  Consumer stage behind the blitter command FIFO. Takes one 128-bit command at a time,

---
 rtl/blit_pkg.sv | 44 ++++
 rtl/blit_raster_walker.sv | 63 ++++++
 rtl/blit_sequencer.sv | 144 ++++++++++++++
 tb/tb_blit_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared blitter definitions: opcodes, command layout, field positions, sequencer states.
package blit_pkg;

  localparam int unsigned CMD_W          = 128;
  localparam int unsigned OPCODE_LSB     = 120;
  localparam int unsigned WIDTH_LSB      = 108;
  localparam int unsigned HEIGHT_LSB     = 96;
  localparam int unsigned X_LSB          = 80;
  localparam int unsigned Y_LSB          = 64;
  localparam int unsigned ADDR_LSB       = 32;
  localparam int unsigned SRC_STRIDE_LSB = 16;
  localparam int unsigned DST_STRIDE_LSB = 0;
  localparam int unsigned COLOUR_LSB     = 0;

  typedef enum logic [7:0] {
    BLIT_NOP      = 8'h00,
    BLIT_FILL     = 8'h01,
    BLIT_COPY     = 8'h02,
    BLIT_SET_DEST = 8'h03
  } blit_op_e;

  // Colour of a FILL shares bits [7:0] with the dst stride field of SET_DEST.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [11:0] width;
    logic [11:0] height;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] addr;
    logic [15:0] src_stride;
    logic [15:0] dst_stride;
  } blit_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StRun
  } blit_state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return op <= 8'h03;
  endfunction

endpackage

// File: rtl/blit_raster_walker.sv
// Raster walker: col/row counters and row-base accumulators producing per-pixel addresses.
module blit_raster_walker #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_dst,
  input  logic [ADDR_W-1:0] start_src,
  input  logic [ADDR_W-1:0] dst_stride,
  input  logic [ADDR_W-1:0] src_stride,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [ADDR_W-1:0] cur_dst,
  output logic [ADDR_W-1:0] cur_src,
  output logic              last
);

  logic [DIM_W-1:0]  col_q, row_q;
  logic [ADDR_W-1:0] row_dst_q, row_src_q, cur_dst_q, cur_src_q;
  logic              col_last, row_last;

  assign col_last = (col_q == width - DIM_W'(1));
  assign row_last = (row_q == height - DIM_W'(1));
  assign last     = col_last && row_last;
  assign cur_dst  = cur_dst_q;
  assign cur_src  = cur_src_q;

  // Load row bases at setup, then step one pixel per accepted request.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      row_dst_q <= '0;
      row_src_q <= '0;
      cur_dst_q <= '0;
      cur_src_q <= '0;
    end else if (load) begin
      col_q     <= '0;
      row_q     <= '0;
      row_dst_q <= start_dst;
      row_src_q <= start_src;
      cur_dst_q <= start_dst;
      cur_src_q <= start_src;
    end else if (step) begin
      if (!col_last) begin
        col_q     <= col_q + DIM_W'(1);
        cur_dst_q <= cur_dst_q + ADDR_W'(1);
        cur_src_q <= cur_src_q + ADDR_W'(1);
      end else if (!row_last) begin
        col_q     <= '0;
        row_q     <= row_q + DIM_W'(1);
        row_dst_q <= row_dst_q + dst_stride;
        row_src_q <= row_src_q + src_stride;
        cur_dst_q <= row_dst_q + dst_stride;
        cur_src_q <= row_src_q + src_stride;
      end
    end
  end

endmodule

// File: rtl/blit_sequencer.sv
// Blit sequencer: pops commands, keeps destination state, expands FILL/COPY into pixel requests.
module blit_sequencer
  import blit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [127:0]      cmd_in,
  input  logic              cmd_in_valid,
  output logic              next_cmd,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_op,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] pix_src_addr,
  output logic [7:0]        pix_data,
  output logic              busy,
  output logic              cmd_error
);

  blit_state_e       state_q, state_d;
  blit_cmd_t         in_cmd;
  logic              in_rect;
  logic              accept, last, load;

  logic [7:0]        op_q;
  logic [11:0]       width_q, height_q;
  logic [15:0]       x_q, y_q;
  logic [31:0]       addr_q;
  logic [7:0]        colour_q;
  logic [ADDR_W-1:0] dst_base_q;
  logic [15:0]       dst_stride_q, src_stride_q;
  logic              pix_valid_q, cmd_error_q;

  logic [ADDR_W-1:0] start_dst, y_ext, x_ext, dst_stride_ext, cur_dst, cur_src;

  assign in_cmd  = blit_cmd_t'(cmd_in);
  assign accept  = pix_valid_q && pix_ready;
  // Only non-empty FILL/COPY rectangles leave IDLE.
  assign in_rect = ((in_cmd.opcode == BLIT_FILL) || (in_cmd.opcode == BLIT_COPY)) &&
                   (in_cmd.width != '0) && (in_cmd.height != '0);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_in_valid && in_rect) state_d = StSetup;
      StSetup: state_d = StRun;
      StRun:   if (accept && last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; the pop strobe is combinational so commands can be taken every cycle.
  always_comb begin
    next_cmd = (state_q == StIdle) && cmd_in_valid && !reset;
    busy     = (state_q != StIdle);
    load     = (state_q == StSetup);
  end

  // Command capture, SET_DEST registers and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q         <= '0;
      width_q      <= '0;
      height_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      colour_q     <= '0;
      dst_base_q   <= '0;
      dst_stride_q <= '0;
      src_stride_q <= '0;
      cmd_error_q  <= 1'b0;
    end else if (next_cmd) begin
      op_q     <= in_cmd.opcode;
      width_q  <= in_cmd.width;
      height_q <= in_cmd.height;
      x_q      <= in_cmd.x;
      y_q      <= in_cmd.y;
      addr_q   <= in_cmd.addr;
      colour_q <= in_cmd.dst_stride[7:0];
      if (in_cmd.opcode == BLIT_SET_DEST) begin
        dst_base_q   <= ADDR_W'(in_cmd.addr);
        dst_stride_q <= in_cmd.dst_stride;
        src_stride_q <= in_cmd.src_stride;
      end
      if (!is_legal_op(in_cmd.opcode)) cmd_error_q <= 1'b1;
    end
  end

  // Request valid: raised leaving SETUP, dropped after the last pixel is accepted.
  always_ff @(posedge clock) begin
    if (reset)                pix_valid_q <= 1'b0;
    else if (load)            pix_valid_q <= 1'b1;
    else if (accept && last)  pix_valid_q <= 1'b0;
  end

  // First pixel address; all terms zero-extended and wrapped to ADDR_W.
  always_comb begin
    y_ext          = ADDR_W'(y_q);
    x_ext          = ADDR_W'(x_q);
    dst_stride_ext = ADDR_W'(dst_stride_q);
    start_dst      = dst_base_q + y_ext * dst_stride_ext + x_ext;
  end

  blit_raster_walker #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_walker (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .step       (accept),
    .start_dst  (start_dst),
    .start_src  (ADDR_W'(addr_q)),
    .dst_stride (dst_stride_ext),
    .src_stride (ADDR_W'(src_stride_q)),
    .width      (DIM_W'(width_q)),
    .height     (DIM_W'(height_q)),
    .cur_dst    (cur_dst),
    .cur_src    (cur_src),
    .last       (last)
  );

  // Pixel request outputs derived from captured command and walker position.
  always_comb begin
    pix_valid    = pix_valid_q;
    pix_op       = (op_q == BLIT_COPY);
    pix_addr     = cur_dst;
    pix_src_addr = (op_q == BLIT_COPY) ? cur_src : '0;
    pix_data     = (op_q == BLIT_FILL) ? colour_q : '0;
    cmd_error    = cmd_error_q;
  end

endmodule

// File: tb/tb_blit_sequencer.sv
// Self-checking bench for blit_sequencer: FIFO model, reference pixel model, directed + random.
module tb_blit_sequencer;
  import blit_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] cmd_in;
  logic         cmd_in_valid;
  logic         next_cmd, pix_valid, pix_ready, pix_op, busy, cmd_error;
  logic [31:0]  pix_addr, pix_src_addr;
  logic [7:0]   pix_data;

  always #5 clock = ~clock;

  blit_sequencer #(.ADDR_W(32), .DIM_W(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_in       (cmd_in),
    .cmd_in_valid (cmd_in_valid),
    .next_cmd     (next_cmd),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_op       (pix_op),
    .pix_addr     (pix_addr),
    .pix_src_addr (pix_src_addr),
    .pix_data     (pix_data),
    .busy         (busy),
    .cmd_error    (cmd_error)
  );

  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [31:0] src;
    logic [7:0]  data;
  } pix_t;

  logic [127:0] fifo[$];
  pix_t         obs_q[$], exp_q[$];
  int           acc_cyc[$];
  int           n_cmp = 0, n_bad = 0;
  int           pop_cnt = 0, run_len = 0, max_run = 0, cyc = 0, ready_mode = 0;
  bit           pv_seen = 0, busy_seen = 0, hold_pending = 0;
  pix_t         held;

  // Reference state, from the command semantics only.
  logic [31:0]  m_base = '0;
  logic [15:0]  m_dstr = '0, m_sstr = '0;
  logic         m_err = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] op, input logic [11:0] w,
                                      input logic [11:0] h, input logic [15:0] x,
                                      input logic [15:0] y, input logic [31:0] a,
                                      input logic [15:0] ss, input logic [15:0] ds);
    logic [127:0] c = '0;
    c[OPCODE_LSB +: 8]      = op;
    c[WIDTH_LSB +: 12]      = w;
    c[HEIGHT_LSB +: 12]     = h;
    c[X_LSB +: 16]          = x;
    c[Y_LSB +: 16]          = y;
    c[ADDR_LSB +: 32]       = a;
    c[SRC_STRIDE_LSB +: 16] = ss;
    c[DST_STRIDE_LSB +: 16] = ds;
    return c;
  endfunction

  // Expected pixels: pixel (r,k) of a rectangle at base+(y+r)*dstride+x+k, src+r*sstride+k.
  task automatic model(input logic [127:0] c);
    logic [7:0]  op = c[OPCODE_LSB +: 8];
    int unsigned w  = c[WIDTH_LSB +: 12];
    int unsigned h  = c[HEIGHT_LSB +: 12];
    logic [31:0] x  = 32'(c[X_LSB +: 16]);
    logic [31:0] y  = 32'(c[Y_LSB +: 16]);
    logic [31:0] a  = c[ADDR_LSB +: 32];
    pix_t        p;
    case (op)
      8'h00: ;
      8'h01, 8'h02: begin
        for (int r = 0; r < int'(h); r++) begin
          for (int k = 0; k < int'(w); k++) begin
            p.op   = (op == 8'h02);
            p.addr = m_base + (y + 32'(r)) * 32'(m_dstr) + x + 32'(k);
            p.src  = (op == 8'h02) ? a + 32'(r) * 32'(m_sstr) + 32'(k) : 32'h0;
            p.data = (op == 8'h01) ? c[COLOUR_LSB +: 8] : 8'h0;
            exp_q.push_back(p);
          end
        end
      end
      8'h03: begin
        m_base = a;
        m_sstr = c[SRC_STRIDE_LSB +: 16];
        m_dstr = c[DST_STRIDE_LSB +: 16];
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic push(input logic [127:0] c);
    fifo.push_back(c);
    model(c);
  endtask

  // FIFO and engine side: drive at negedge, sample just after, ahead of the next posedge.
  always @(negedge clock) begin
    cmd_in       = (fifo.size() > 0) ? fifo[0] : '0;
    cmd_in_valid = (fifo.size() > 0);
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
    #1;
    if (reset) begin
      hold_pending = 0;
      run_len      = 0;
    end else begin
      if (hold_pending)
        check("stall_hold", {pix_valid, pix_op, pix_addr, pix_src_addr, pix_data}, {1'b1, held});
      hold_pending = pix_valid && !pix_ready;
      if (hold_pending) held = {pix_op, pix_addr, pix_src_addr, pix_data};
      if (next_cmd) begin
        void'(fifo.pop_front());
        pop_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (pix_valid) pv_seen = 1;
      if (busy) busy_seen = 1;
      if (pix_valid && pix_ready) begin
        obs_q.push_back({pix_op, pix_addr, pix_src_addr, pix_data});
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_done(input string tag);
    int t = 0;
    while (fifo.size() > 0 && t < 3000) begin @(negedge clock); t++; end
    repeat (3) @(negedge clock);
    while ((busy || pix_valid) && t < 3000) begin @(negedge clock); t++; end
    check({tag, " in_time"}, 128'(t < 3000), 128'(1));
    #2;
  endtask

  task automatic compare_pix(input string tag);
    check({tag, " count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    acc_cyc.delete();
  endtask

  initial begin
    reset        = 1'b1;
    pix_ready    = 1'b1;
    cmd_in       = '0;
    cmd_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    check("rst pix_valid", pix_valid, 0);
    check("rst busy", busy, 0);
    check("rst cmd_error", cmd_error, 0);
    check("rst next_cmd", next_cmd, 0);
    check("rst pix_outs", {pix_op, pix_addr, pix_src_addr, pix_data}, 0);
    @(negedge clock);
    reset = 1'b0;

    // 1: SET_DEST then FILL 3x2 at (5,1), continuous ready.
    @(negedge clock);
    push(mk(8'h03, 0, 0, 0, 0, 32'h1000, 16'd0, 16'd320));
    push(mk(8'h01, 3, 2, 5, 1, 0, 0, 16'h00AB));
    wait_done("t1");
    check("t1 first addr", (obs_q.size() > 0) ? obs_q[0].addr : 32'hx, 32'h1145);
    check("t1 last addr", (obs_q.size() == 6) ? obs_q[5].addr : 32'hx, 32'h1287);
    check("t1 no bubbles", (acc_cyc.size() == 6) ? acc_cyc[5] - acc_cyc[0] : -1, 5);
    check("t1 busy", busy, 0);
    compare_pix("t1 pix");

    // 2: COPY 2x2 with src stride 16, ready toggling.
    ready_mode = 1;
    push(mk(8'h03, 0, 0, 0, 0, 32'h2000, 16'd16, 16'd64));
    push(mk(8'h02, 2, 2, 0, 0, 32'h8000, 0, 0));
    wait_done("t2");
    check("t2 last src", (obs_q.size() == 4) ? obs_q[3].src : 32'hx, 32'h8011);
    compare_pix("t2 pix");
    ready_mode = 0;

    // 3: NOP, SET_DEST, NOP back-to-back.
    @(negedge clock);
    pop_cnt = 0; max_run = 0; busy_seen = 0;
    push(mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    push(mk(8'h03, 0, 0, 0, 0, 32'h4000, 16'd8, 16'd100));
    push(mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    wait_done("t3");
    check("t3 pops", pop_cnt, 3);
    check("t3 consecutive", max_run, 3);
    check("t3 busy_seen", busy_seen, 0);
    push(mk(8'h01, 2, 2, 1, 1, 0, 0, 16'h005A));
    wait_done("t3b");
    check("t3 dest regs", (obs_q.size() > 0) ? obs_q[0].addr : 32'hx, 32'h4065);
    compare_pix("t3 pix");

    // 4: illegal opcode then zero-width FILL.
    @(negedge clock);
    pop_cnt = 0; pv_seen = 0; busy_seen = 0;
    push(mk(8'h7F, 1, 1, 0, 0, 0, 0, 0));
    push(mk(8'h01, 0, 5, 0, 0, 0, 0, 16'h0011));
    wait_done("t4");
    check("t4 cmd_error", cmd_error, m_err);
    check("t4 pops", pop_cnt, 2);
    check("t4 no pix", pv_seen, 0);
    check("t4 no busy", busy_seen, 0);
    push(mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    wait_done("t4b");
    check("t4 sticky", cmd_error, 1);
    compare_pix("t4 pix");

    // 5: reset after 37 accepts of a 10x10 FILL.
    push(mk(8'h03, 0, 0, 0, 0, 32'h10000, 16'd0, 16'd50));
    push(mk(8'h01, 10, 10, 0, 0, 0, 0, 16'h0077));
    begin
      int t = 0;
      while (obs_q.size() < 37 && t < 1000) begin @(negedge clock); t++; end
      check("t5 reach 37", 128'(t < 1000), 128'(1));
    end
    reset = 1'b1;
    @(negedge clock);
    #2;
    check("t5 accepts", obs_q.size(), 37);
    check("t5 pix_valid", pix_valid, 0);
    check("t5 busy", busy, 0);
    check("t5 cmd_error", cmd_error, 0);
    check("t5 pix_addr", pix_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    obs_q.delete(); exp_q.delete(); acc_cyc.delete(); fifo.delete();
    m_base = '0; m_dstr = '0; m_sstr = '0; m_err = 1'b0;
    push(mk(8'h01, 3, 2, 2, 1, 0, 0, 16'h0033));
    wait_done("t5b");
    check("t5 regs cleared", (obs_q.size() == 6) ? obs_q[3].addr : 32'hx, 32'h2);
    compare_pix("t5 pix");

    // 6: destination wrap.
    push(mk(8'h03, 0, 0, 0, 0, 32'hFFFF_FFFF, 16'd0, 16'd16));
    push(mk(8'h01, 1, 1, 1, 0, 0, 0, 16'h0011));
    wait_done("t6");
    check("t6 wrap addr", (obs_q.size() == 1) ? obs_q[0].addr : 32'hx, 32'h0);
    compare_pix("t6 pix");

    // Random commands against the reference model, random ready.
    ready_mode = 2;
    for (int i = 0; i < 14; i++) begin
      int n = (i % 3 == 0) ? 2 : 1;
      for (int j = 0; j < n; j++) begin
        push(mk(8'($urandom_range(0, 3)), 12'($urandom_range(0, 5)), 12'($urandom_range(0, 4)),
                16'($urandom), 16'($urandom), $urandom, 16'($urandom), 16'($urandom)));
      end
      wait_done("rnd");
      compare_pix("rnd pix");
      check("rnd cmd_error", cmd_error, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
